bypass_hazard_unit: RTL and testbench

Parametrised successor to the single-case MX bypass detector. Tracks in-flight register writers through the X, M and W stages. For each execute-stage source it generates forward selects for MX and WX bypass. It also raises decode stalls for load-use hazards and for conflicts with a multi-cycle mult/div unit. It sits between the decode latch and the execute operand muxes of the 5-stage core.

---
 rtl/bypass_hazard_unit.sv | 142 ++++++++++++++
 tb/tb_bypass_hazard_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bypass_hazard_unit.sv
// rtl/bypass_hazard_unit.sv - MX/WX forward selects plus load-use and mult/div decode stalls
// Optional HAZARD_PERF_EN adds a saturating stall cycle counter on port stall_count.
module bypass_hazard_unit #(
    parameter int REG_BITS  = 5,
    parameter int OP_BITS   = 5,
    parameter int MD_CYCLES = 32,
    parameter int CNT_BITS  = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                d_valid,
    input  logic [OP_BITS-1:0]  d_opcode,
    input  logic [4:0]          d_aluop,
    input  logic [REG_BITS-1:0] d_rd,
    input  logic [REG_BITS-1:0] d_rs,
    input  logic [REG_BITS-1:0] d_rt,
    output logic                stall,
    output logic [1:0]          fwd_a_sel,
    output logic [1:0]          fwd_b_sel,
    output logic [1:0]          fwd_st_sel,
    output logic                md_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_BITS-1:0] stall_count
`endif
);

    localparam logic [OP_BITS-1:0] OP_R    = OP_BITS'(5'b00000);
    localparam logic [OP_BITS-1:0] OP_ADDI = OP_BITS'(5'b00101);
    localparam logic [OP_BITS-1:0] OP_SW   = OP_BITS'(5'b00111);
    localparam logic [OP_BITS-1:0] OP_LW   = OP_BITS'(5'b01000);
    localparam int MD_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;

    typedef struct packed {
        logic                valid;
        logic                wr;
        logic                is_load;
        logic                is_md;
        logic [REG_BITS-1:0] rd;
        logic [REG_BITS-1:0] rs;
        logic [REG_BITS-1:0] rt;
        logic                uses_a;
        logic                uses_b;
        logic                uses_st;
    } rec_t;

    rec_t                x_q, m_q, w_q, d_rec, x_d;
    logic [MD_W-1:0]     md_cnt_q;
    logic                md_busy_q;
    logic [REG_BITS-1:0] md_rd_q;
    logic                is_r, is_addi, is_sw, is_lw, d_is_md;
    logic                load_use, md_hit, d_touch_md;
    logic                unused_ok;

    function automatic logic [1:0] pick(input logic use_src, input logic [REG_BITS-1:0] src,
                                        input rec_t m, input rec_t w);
        if (use_src && m.wr && !m.is_load && m.rd == src) return 2'd1;
        if (use_src && w.wr && w.rd == src)               return 2'd2;
        return 2'd0;
    endfunction

    always_comb begin
        is_r    = (d_opcode == OP_R);
        is_addi = (d_opcode == OP_ADDI);
        is_sw   = (d_opcode == OP_SW);
        is_lw   = (d_opcode == OP_LW);
        d_is_md = d_valid && is_r && (d_aluop == 5'b00110 || d_aluop == 5'b00111);
        d_rec   = '0;
        if (d_valid) begin
            d_rec.valid   = 1'b1;
            d_rec.rd      = d_rd;
            d_rec.rs      = d_rs;
            d_rec.rt      = d_rt;
            d_rec.uses_a  = is_r || is_addi || is_lw || is_sw;
            d_rec.uses_b  = is_r;
            d_rec.uses_st = is_sw;
            // Writers to r0 are dropped here so nothing downstream needs an r0 check
            d_rec.wr      = ((is_r && !d_is_md) || is_addi || is_lw) && (d_rd != '0);
            d_rec.is_load = is_lw;
            d_rec.is_md   = d_is_md;
        end
    end

    always_comb begin
        load_use = x_q.is_load && x_q.wr &&
                   ((d_rec.uses_a  && d_rs == x_q.rd) ||
                    (d_rec.uses_b  && d_rt == x_q.rd) ||
                    (d_rec.uses_st && d_rd == x_q.rd));
        d_touch_md = (md_rd_q != '0) &&
                     ((d_rec.uses_a  && d_rs == md_rd_q) ||
                      (d_rec.uses_b  && d_rt == md_rd_q) ||
                      (d_rec.uses_st && d_rd == md_rd_q) ||
                      ((d_rec.wr || d_is_md) && d_rd == md_rd_q));
        md_hit = md_busy_q && (d_touch_md || d_is_md);
        stall  = d_valid && (load_use || md_hit);
        x_d    = stall ? '0 : d_rec;
    end

    always_comb begin
        fwd_a_sel  = pick(x_q.uses_a,  x_q.rs, m_q, w_q);
        fwd_b_sel  = pick(x_q.uses_b,  x_q.rt, m_q, w_q);
        fwd_st_sel = pick(x_q.uses_st, x_q.rd, m_q, w_q);
    end

    assign md_busy   = md_busy_q;
    assign unused_ok = ^{x_q.valid, m_q, w_q};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
            md_cnt_q  <= '0;
            md_busy_q <= 1'b0;
            md_rd_q   <= '0;
        end else begin
            x_q <= x_d;
            m_q <= x_q;
            w_q <= m_q;
            // A mul/div reaching X (re)arms the occupancy window
            if (x_q.is_md) begin
                md_cnt_q  <= MD_W'(MD_CYCLES - 1);
                md_busy_q <= 1'b1;
                md_rd_q   <= x_q.rd;
            end else if (md_busy_q) begin
                if (md_cnt_q == '0) md_busy_q <= 1'b0;
                else                md_cnt_q  <= md_cnt_q - 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_BITS-1:0] stall_count_q;
    assign stall_count = stall_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                               stall_count_q <= '0;
        else if (stall && stall_count_q != '1)   stall_count_q <= stall_count_q + 1'b1;
    end
`endif

endmodule

// File: tb/tb_bypass_hazard_unit.sv
// tb/tb_bypass_hazard_unit.sv - directed and randomized checks of bypass_hazard_unit against an instruction-level model
module tb_bypass_hazard_unit;
    localparam int MDC  = 4;
    localparam int CNTB = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_opcode, d_aluop, d_rd, d_rs, d_rt;
    logic       stall, md_busy;
    logic [1:0] fwd_a_sel, fwd_b_sel, fwd_st_sel;
`ifdef HAZARD_PERF_EN
    logic [CNTB-1:0] stall_count;
`endif

    bypass_hazard_unit #(.REG_BITS(5), .OP_BITS(5), .MD_CYCLES(MDC), .CNT_BITS(CNTB)) dut (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_opcode(d_opcode),
        .d_aluop(d_aluop), .d_rd(d_rd), .d_rs(d_rs), .d_rt(d_rt), .stall(stall),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .fwd_st_sel(fwd_st_sel),
        .md_busy(md_busy)
`ifdef HAZARD_PERF_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       v;
        logic [4:0] op, alu, rd, rs, rt;
    } ins_t;

    int         checks = 0;
    int         failures = 0;
    ins_t       px, pm, pw;
    int         md_left;
    logic [4:0] md_rd;
    int         exp_cnt;
    logic       last_stall;
    logic       obs_stall, obs_busy;
    logic [1:0] obs_a, obs_b, obs_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ins_t mk(input int op, input int alu, input int rd, input int rs, input int rt);
        ins_t i;
        i.v = 1'b1; i.op = 5'(op); i.alu = 5'(alu); i.rd = 5'(rd); i.rs = 5'(rs); i.rt = 5'(rt);
        return i;
    endfunction

    function automatic bit is_md(input ins_t i);
        return i.v && i.op == 0 && (i.alu == 6 || i.alu == 7);
    endfunction
    function automatic bit writes(input ins_t i);
        return i.v && i.rd != 0 && ((i.op == 0 && !is_md(i)) || i.op == 5 || i.op == 8);
    endfunction
    function automatic bit use_a(input ins_t i);
        return i.v && (i.op == 0 || i.op == 5 || i.op == 7 || i.op == 8);
    endfunction
    function automatic bit use_b(input ins_t i);
        return i.v && i.op == 0;
    endfunction
    function automatic bit use_st(input ins_t i);
        return i.v && i.op == 7;
    endfunction
    function automatic bit reads(input ins_t i, input logic [4:0] r);
        return r != 0 && ((use_a(i) && i.rs == r) || (use_b(i) && i.rt == r) || (use_st(i) && i.rd == r));
    endfunction
    function automatic logic [1:0] exp_sel(input bit used, input logic [4:0] src);
        if (used && writes(pm) && pm.rd == src && pm.op != 8) return 2'd1;
        if (used && writes(pw) && pw.rd == src) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        px = '0; pm = '0; pw = '0; md_left = 0; md_rd = '0; exp_cnt = 0; last_stall = 1'b0;
    endtask

    task automatic step(input ins_t d);
        bit es;
        @(negedge clock);
        d_valid = d.v; d_opcode = d.op; d_aluop = d.alu; d_rd = d.rd; d_rs = d.rs; d_rt = d.rt;
        #1;
        es = d.v && ((px.op == 8 && writes(px) && reads(d, px.rd)) ||
                     (md_left > 0 && (is_md(d) || (md_rd != 0 &&
                       (reads(d, md_rd) || ((writes(d) || is_md(d)) && d.rd == md_rd))))));
        obs_stall = stall; obs_busy = md_busy;
        obs_a = fwd_a_sel; obs_b = fwd_b_sel; obs_s = fwd_st_sel;
        chk("stall", 32'(obs_stall), 32'(es));
        chk("md_busy", 32'(obs_busy), 32'(md_left > 0));
        chk("fwd_a", 32'(obs_a), 32'(exp_sel(use_a(px), px.rs)));
        chk("fwd_b", 32'(obs_b), 32'(exp_sel(use_b(px), px.rt)));
        chk("fwd_st", 32'(obs_s), 32'(exp_sel(use_st(px), px.rd)));
`ifdef HAZARD_PERF_EN
        chk("stall_count", 32'(stall_count), 32'(exp_cnt));
`endif
        @(posedge clock);
        if (is_md(px)) begin
            md_left = MDC; md_rd = px.rd;
        end else if (md_left > 0) begin
            md_left--;
        end
        if (es && exp_cnt != (1 << CNTB) - 1) exp_cnt++;
        pw = pm; pm = px; px = es ? '0 : d;
        last_stall = es;
    endtask

    task automatic issue(input ins_t d, output int nst);
        nst = 0;
        for (int k = 0; k < 40; k++) begin
            step(d);
            if (!last_stall) return;
            nst++;
        end
        checks++; failures++;
        $error("FAIL issue_bound observed=%0d expected=<40", nst);
    endtask

    task automatic flush(input int n);
        int dummy;
        for (int k = 0; k < n; k++) issue('0, dummy);
    endtask

    initial begin
        int n;
        ins_t d;
        reset = 1'b1; d_valid = 1'b0; d_opcode = '0; d_aluop = '0; d_rd = '0; d_rs = '0; d_rt = '0;
        model_reset();
        @(negedge clock); #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_fwd", 32'({fwd_a_sel, fwd_b_sel, fwd_st_sel}), 32'd0);
        @(negedge clock); reset = 1'b0;

        // addi r3 ; add r4,r3,r5 -> MX forward on A
        issue(mk(5, 0, 3, 1, 0), n);
        issue(mk(0, 0, 4, 3, 5), n);
        chk("tp1_stall", 32'(obs_stall), 32'd0);
        step('0);
        chk("tp1_fwd_a", 32'(obs_a), 32'd1);

        // addi r3 ; nop ; sw r3,0(r7) -> WX forward on store data
        flush(3);
        issue(mk(5, 0, 3, 1, 0), n);
        issue('0, n);
        issue(mk(7, 0, 3, 7, 0), n);
        step('0);
        chk("tp2_fwd_st", 32'(obs_s), 32'd2);
        chk("tp2_fwd_a", 32'(obs_a), 32'd0);

        // lw r2,0(r1) ; add r6,r2,r2 -> one stall then WX on both operands
        flush(3);
        issue(mk(8, 0, 2, 1, 0), n);
        issue(mk(0, 0, 6, 2, 2), n);
        chk("tp3_stalls", 32'(n), 32'd1);
        step('0);
        chk("tp3_fwd_a", 32'(obs_a), 32'd2);
        chk("tp3_fwd_b", 32'(obs_b), 32'd2);

        // mul r8 ; nop ; add r9,r8,r1 -> stalled for the whole busy window
        flush(6);
        issue(mk(0, 6, 8, 1, 2), n);
        issue('0, n);
        issue(mk(0, 0, 9, 8, 1), n);
        chk("tp4_stalls", 32'(n), 32'(MDC));
        flush(6);
        issue(mk(0, 7, 8, 1, 2), n);
        issue('0, n);
        step(mk(0, 0, 9, 1, 2));
        chk("tp4_indep_stall", 32'(obs_stall), 32'd0);
        chk("tp4_indep_busy", 32'(obs_busy), 32'd1);

        // writer to r0 then reader of r0
        flush(6);
        issue(mk(5, 0, 0, 1, 0), n);
        issue(mk(0, 0, 1, 0, 0), n);
        chk("tp5_stall", 32'(obs_stall), 32'd0);
        step('0);
        chk("tp5_fwd", 32'({obs_a, obs_b}), 32'd0);

        // reset in the middle of a mult/div window
        flush(3);
        issue(mk(0, 6, 8, 1, 2), n);
        issue('0, n);
        step(mk(0, 0, 9, 8, 1));
        chk("tp6_pre_busy", 32'(obs_busy), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("tp6_busy", 32'(md_busy), 32'd0);
        chk("tp6_stall", 32'(stall), 32'd0);
        chk("tp6_fwd", 32'({fwd_a_sel, fwd_b_sel, fwd_st_sel}), 32'd0);
`ifdef HAZARD_PERF_EN
        chk("tp6_count", 32'(stall_count), 32'd0);
`endif
        model_reset();
        @(negedge clock); reset = 1'b0;

        // randomized instruction stream over a small register set
        for (int it = 0; it < 400; it++) begin
            int ops[6] = '{0, 0, 5, 7, 8, 3};
            d = mk(ops[$urandom_range(0, 5)], $urandom_range(0, 7),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            d.v = ($urandom_range(0, 7) != 0);
            issue(d, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
